// File: rtl/fetch_responder.sv
// fetch_responder: turns 16-bit halfword-aligned instruction fetches into one
// or two reads of a 32-bit synchronous program memory and returns the 32-bit
// instruction with the halfword at the request address in [31:16].
// Optional feature: define IMEM_ERR_EN to add the rsp_err port and an
// out-of-range check against MEM_WORDS.
module fetch_responder #(
  parameter int MEM_WORDS = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
`ifdef IMEM_ERR_EN
  output logic        rsp_err,
`endif
  output logic        mem_en,
  output logic [13:0] mem_addr,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD0  = 2'd1,
    RD1  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [13:0] word_q, word_d;       // word index of the first halfword
  logic        half_q, half_d;       // 1: first halfword is in the upper half
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        mem_en_s;
  logic [13:0] mem_addr_s;
  logic        req_err_s;
  logic        unused_s;

  // Byte bit 0 of the address never selects anything; the parameter only
  // matters when the range check is built in.
  assign unused_s = req_addr[0] ^ (MEM_WORDS > 0);

`ifdef IMEM_ERR_EN
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

  logic        rsp_err_q, rsp_err_d;
  logic [13:0] req_next_word_s;

  // Flag a request whose first word, or wrapped second word, is out of range.
  always_comb begin
    req_next_word_s = req_addr[15:2] + 14'd1;
    req_err_s = (32'(req_addr[15:2]) >= MEM_LIMIT) ||
                (req_addr[1] && (32'(req_next_word_s) >= MEM_LIMIT));
  end

  assign rsp_err = rsp_err_q;
`else
  assign req_err_s = 1'b0;
`endif

  // Next-state, datapath loads and memory strobe for the fetch sequence.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    half_d     = half_q;
    rsp_data_d = rsp_data_q;
`ifdef IMEM_ERR_EN
    rsp_err_d  = rsp_err_q;
`endif
    mem_en_s   = 1'b0;
    mem_addr_s = 14'd0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          word_d = req_addr[15:2];
          half_d = req_addr[1];
          if (req_err_s) begin
            // Bad fetch: skip memory entirely and answer on the next cycle.
            rsp_data_d = 32'd0;
`ifdef IMEM_ERR_EN
            rsp_err_d  = 1'b1;
`endif
            state_d    = RESP;
          end else begin
            mem_en_s   = 1'b1;
            mem_addr_s = req_addr[15:2];
`ifdef IMEM_ERR_EN
            rsp_err_d  = 1'b0;
`endif
            state_d    = RD0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD0: begin
        if (half_q) begin
          // Instruction straddles two words; the 14-bit add wraps naturally.
          rsp_data_d = {mem_rdata[31:16], rsp_data_q[15:0]};
          mem_en_s   = 1'b1;
          mem_addr_s = word_q + 14'd1;
          state_d    = RD1;
        end else begin
          rsp_data_d = {mem_rdata[15:0], mem_rdata[31:16]};
          state_d    = RESP;
        end
      end
      RD1: begin
        rsp_data_d = {rsp_data_q[31:16], mem_rdata[15:0]};
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any fetch in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      word_q     <= 14'd0;
      half_q     <= 1'b0;
      rsp_data_q <= 32'd0;
`ifdef IMEM_ERR_EN
      rsp_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      half_q     <= half_d;
      rsp_data_q <= rsp_data_d;
`ifdef IMEM_ERR_EN
      rsp_err_q  <= rsp_err_d;
`endif
    end
  end

  // The memory strobe is combinational, so hold it quiet while in reset.
  assign mem_en    = mem_en_s & ~rst;
  assign mem_addr  = rst ? 14'd0 : mem_addr_s;
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_fetch_responder.sv
// Directed self-checking bench for fetch_responder with a scoreboard queue of
// expected instruction words and a behavioural synchronous program memory.
module tb_fetch_responder;

`ifdef IMEM_ERR_EN
  localparam int TB_WORDS = 256;
`else
  localparam int TB_WORDS = 16384;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        mem_en;
  logic [13:0] mem_addr;
  logic [31:0] mem_rdata = 32'd0;

  logic [31:0] mem [0:16383];
  logic [31:0] sb [$];
  logic [13:0] mem_log [$];
  int          rsp_seen = 0;
  int          tests = 0;
  int          failed = 0;

  fetch_responder #(.MEM_WORDS(TB_WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
`ifdef IMEM_ERR_EN
    .rsp_err   (rsp_err),
`endif
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

`ifndef IMEM_ERR_EN
  assign rsp_err = 1'b0;
`endif

  always #5 clk = ~clk;

  // Synchronous program memory: data one cycle after the strobe.
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= mem[mem_addr];
  end

  // Record every memory strobe and every cycle with a response shown.
  always @(negedge clk) begin
    if (mem_en) mem_log.push_back(mem_addr);
    if (rsp_valid) rsp_seen = rsp_seen + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete fetch: drive, wait for the response, optionally stall it,
  // then compare data, latency, memory traffic and return to IDLE.
  task automatic fetch(input string name, input logic [15:0] addr, input logic [31:0] exp_data,
                       input int exp_lat, input int exp_n, input logic [13:0] a0,
                       input logic [13:0] a1, input logic exp_err, input int hold);
    int          lat;
    logic [31:0] got;
    logic [31:0] expq;
    mem_log.delete();
    sb.push_back(exp_data);
    step();
    check({name, "_ready_idle"}, req_ready, 1'b1);
    req_valid = 1'b1;
    req_addr  = addr;
    rsp_ready = (hold == 0);
    step();
    req_valid = 1'b0;
    req_addr  = addr ^ 16'h5A5A;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 8) begin
      check({name, "_ready_busy"}, req_ready, 1'b0);
      step();
      lat++;
    end
    check({name, "_rsp_valid"}, rsp_valid, 1'b1);
    check({name, "_latency"}, lat, exp_lat);
    got = rsp_data;
`ifdef IMEM_ERR_EN
    check({name, "_rsp_err"}, rsp_err, exp_err);
`else
    check({name, "_rsp_err_cfg"}, rsp_err, exp_err & 1'b0);
`endif
    for (int i = 0; i < hold; i++) begin
      check({name, "_hold_valid"}, rsp_valid, 1'b1);
      check({name, "_hold_data"}, rsp_data, got);
      check({name, "_hold_ready"}, req_ready, 1'b0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    expq = sb.pop_front();
    check({name, "_data"}, got, expq);
    check({name, "_idle_valid"}, rsp_valid, 1'b0);
    check({name, "_idle_ready"}, req_ready, 1'b1);
    check({name, "_mem_count"}, mem_log.size(), exp_n);
    if (exp_n > 0 && mem_log.size() > 0) check({name, "_mem_addr0"}, mem_log[0], a0);
    if (exp_n > 1 && mem_log.size() > 1) check({name, "_mem_addr1"}, mem_log[1], a1);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b1;
    req_addr  = 16'h0040;
    rsp_ready = 1'b0;
    mem[14'h010] = 32'hB2A12003;
    mem[14'h011] = 32'hFFFF4770;
    mem[14'h0FF] = 32'h12345678;
    mem[14'h3FFF] = 32'hAAAA0000;
    mem[14'h0000] = 32'h0000BBBB;
    #1;
    step();
    // Reset values, with a request pending that must not strobe memory.
    check("rst_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_mem_addr", mem_addr, 14'd0);
    req_valid = 1'b0;
    rst = 1'b0;
    step();

    fetch("aligned", 16'h0040, 32'h2003B2A1, 2, 1, 14'h010, 14'h000, 1'b0, 0);
    fetch("bit0_ignored", 16'h0041, 32'h2003B2A1, 2, 1, 14'h010, 14'h000, 1'b0, 0);
    mem[14'h010] = 32'h1C8A0000;
    fetch("unaligned", 16'h0042, 32'h1C8A4770, 3, 2, 14'h010, 14'h011, 1'b0, 0);
    fetch("backpressure", 16'h0042, 32'h1C8A4770, 3, 2, 14'h010, 14'h011, 1'b0, 5);
`ifdef IMEM_ERR_EN
    fetch("err_range", 16'h03FE, 32'h00000000, 1, 0, 14'h000, 14'h000, 1'b1, 0);
    fetch("in_range", 16'h03FC, 32'h56781234, 2, 1, 14'h0FF, 14'h000, 1'b0, 0);
`else
    fetch("wrap", 16'hFFFE, 32'hAAAABBBB, 3, 2, 14'h3FFF, 14'h0000, 1'b0, 0);
`endif

    // Reset pulsed while the second word of an unaligned fetch is pending.
    rsp_seen  = 0;
    req_valid = 1'b1;
    req_addr  = 16'h0042;
    rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    check("abort_in_rd1_ready", req_ready, 1'b0);
    rst = 1'b1;
    #1;
    check("abort_rsp_valid", rsp_valid, 1'b0);
    check("abort_rsp_data", rsp_data, 32'd0);
    check("abort_mem_en", mem_en, 1'b0);
    check("abort_ready", req_ready, 1'b1);
    step();
    step();
    rst = 1'b0;
    step();
    check("abort_after_ready", req_ready, 1'b1);
    step();
    step();
    check("abort_no_response", rsp_seen, 0);
    mem[14'h010] = 32'hB2A12003;
    fetch("after_abort", 16'h0040, 32'h2003B2A1, 2, 1, 14'h010, 14'h000, 1'b0, 0);

    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fetch_responder.md
FETCH_RESPONDER -- requirements
Module: fetch_responder

Interface
REQ-001 The block SHALL have one parameter, given as name, default, meaning: MEM_WORDS, 16384, number of 32-bit words implemented in the backing program memory.
REQ-002 The ports SHALL be, given as name, direction, width, meaning:
  clk        in   1   sole clock, rising edge.
  rst        in   1   reset; asynchronous, active-high.
  req_valid  in   1   fetch request present.
  req_ready  out  1   block can accept a request.
  req_addr   in   16  byte address of the instruction; bit 0 is ignored.
  rsp_valid  out  1   rsp_data is valid.
  rsp_ready  in   1   requester accepts the response.
  rsp_data   out  32  [31:16] = halfword at req_addr; [15:0] = halfword at req_addr+2.
  rsp_err    out  1   response is an error; exists only when IMEM_ERR_EN is defined.
  mem_en     out  1   synchronous memory read strobe.
  mem_addr   out  14  memory word address.
  mem_rdata  in   32  read data, valid the cycle after mem_en; the byte-offset-0 halfword is on [15:0] and the offset-2 halfword on [31:16].

Function
REQ-003 The state machine SHALL have exactly four states: IDLE, RD0, RD1, RESP.
REQ-004 req_ready SHALL be 1 only in IDLE, and a request is accepted on a clk edge where req_valid=1 and req_ready=1.
REQ-005 On accept, the block SHALL latch req_addr, drive mem_en=1 with mem_addr=req_addr[15:2] in the same cycle, and move to RD0.
REQ-006 In RD0 with latched addr[1]=0, the block SHALL load rsp_data={mem_rdata[15:0], mem_rdata[31:16]} and move to RESP.
REQ-007 In RD0 with addr[1]=1:
  - the block SHALL latch mem_rdata[31:16] into rsp_data[31:16];
  - it SHALL drive mem_en=1 with mem_addr=addr[15:2]+1, modulo 2^14 (0x3FFF wraps to 0x0000);
  - it SHALL move to RD1.
REQ-008 In RD1, the block SHALL latch mem_rdata[15:0] into rsp_data[15:0] and move to RESP.
REQ-009 Latency from the accept edge to rsp_valid=1 SHALL be 2 cycles for an aligned address and 3 cycles for an unaligned address.
REQ-010 In RESP, rsp_valid SHALL be 1 and rsp_data/rsp_err SHALL hold stable until a clk edge with rsp_ready=1, after which the state SHALL be IDLE.
REQ-011 No request SHALL be accepted while in RD0, RD1 or RESP, so at most one fetch is outstanding and back-to-back fetches are separated by at least one IDLE cycle.
REQ-012 mem_en SHALL be 0 in every cycle other than those named in REQ-005 and REQ-007.
REQ-013 rsp_valid SHALL be 0 in IDLE, RD0 and RD1.
REQ-014 A change on req_addr or req_valid after accept SHALL have no effect on the fetch in progress.

Reset
REQ-015 While rst=1, the block SHALL force:
  - state=IDLE;
  - rsp_valid=0, rsp_data=0, rsp_err=0;
  - mem_en=0, mem_addr=0;
  - req_ready=1 (once rst is deasserted, the block is in IDLE).
REQ-016 Reset asserted during RD0, RD1 or RESP SHALL abort the fetch with no response issued, and the first cycle after deassertion SHALL be IDLE.

Configuration
REQ-017 With IMEM_ERR_EN defined, an accepted request SHALL be an error if any word it needs has an index >= MEM_WORDS, checking addr[15:2] and, when addr[1]=1, addr[15:2]+1 after wrap.
REQ-018 For an error request, the block SHALL issue no mem_en, go directly to RESP on the next cycle, and present rsp_data=0 and rsp_err=1. Non-error responses SHALL have rsp_err=0.
REQ-019 Without IMEM_ERR_EN, the rsp_err port and the range check SHALL be absent, and every address SHALL be fetched normally.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
  - Aligned fetch: memory word 0x10 = 0xB2A12003; request addr 0x0040 with rsp_ready=1 -> exactly one mem_en at addr 0x010; rsp_valid on cycle 2; rsp_data=0x2003B2A1.
  - Unaligned fetch: word 0x10 = 0x1C8A0000 and word 0x11 = 0xFFFF4770; request 0x0042 -> mem_en at 0x010 then 0x011; rsp_valid on cycle 3; rsp_data=0x1C8A4770.
  - Backpressure: rsp_ready held at 0 for 5 cycles -> rsp_valid and rsp_data stable; req_ready=0; one cycle after rsp_ready=1 the block is IDLE with req_ready=1.
  - Wrap: word 0x3FFF = 0xAAAA0000 and word 0x0000 = 0x0000BBBB, no IMEM_ERR_EN; request 0xFFFE -> second mem_addr=0x0000; rsp_data=0xAAAABBBB.
  - Error (IMEM_ERR_EN defined, MEM_WORDS=256): request 0x03FE -> no mem_en; rsp_valid on cycle 1; rsp_err=1; rsp_data=0. Request 0x03FC -> normal response with rsp_err=0.
  - Reset mid-fetch: rst pulsed while in RD1 -> rsp_valid is never asserted, and the next request 0x0040 completes normally.
